// File: rtl/hilo_mult_ctrl.sv
// HI/LO commit controller for the fixed-latency signed 32x32 multiplier.
// Optional multiply-accumulate (op_madd) is compiled in when MADD_EN is defined.
module hilo_mult_ctrl #(
  parameter int MULT_LAT = 2,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_mult,
  input  logic        op_multu,
`ifdef MADD_EN
  input  logic        op_madd,
`endif
  input  logic        op_mthi,
  input  logic        op_mtlo,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [63:0] mult_z,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, WAIT, COMMIT} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             uns_q, acc_q;
  logic             start, start_uns, start_acc;
  logic [63:0]      corr, base, result;

`ifdef MADD_EN
  assign start     = op_mult | op_multu | op_madd;
  assign start_acc = op_madd & ~op_mult & ~op_multu;
`else
  assign start     = op_mult | op_multu;
  assign start_acc = 1'b0;
`endif
  // mult wins over multu when both are pulsed
  assign start_uns = op_multu & ~op_mult;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = WAIT;
      WAIT:    if (cnt == CNT_W'(1)) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == COMMIT);
  end

  // Signed product turned unsigned by adding back each operand's sign-weighted partner
  always_comb begin
    corr   = '0;
    base   = '0;
    if (uns_q)
      corr = (mult_a[31] ? {mult_b, 32'h0} : 64'h0) + (mult_b[31] ? {mult_a, 32'h0} : 64'h0);
    if (acc_q)
      base = {hi, lo};
    result = mult_z + corr + base;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mult_a <= '0;
      mult_b <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      uns_q  <= 1'b0;
      acc_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mult_a <= rs_val;
            mult_b <= rt_val;
            uns_q  <= start_uns;
            acc_q  <= start_acc;
            cnt    <= CNT_W'(MULT_LAT);
          end else begin
            if (op_mthi) hi <= rs_val;
            if (op_mtlo) lo <= rs_val;
          end
        end
        WAIT:    cnt <= cnt - 1'b1;
        COMMIT:  {hi, lo} <= result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Randomized + directed bench for hilo_mult_ctrl with a behavioural multiplier
// and a 64-bit {HI,LO} reference model.
module tb_hilo_mult_ctrl;
  localparam int MULT_LAT = 2;
  localparam int CNT_W    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_mult = 0, op_multu = 0, op_mthi = 0, op_mtlo = 0;
`ifdef MADD_EN
  logic        op_madd = 0;
`endif
  logic [31:0] rs_val = 0, rt_val = 0;
  logic [31:0] mult_a, mult_b, hi, lo;
  logic [63:0] mult_z;
  logic        busy, done;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [63:0] m_hl = 64'h0;

  hilo_mult_ctrl #(.MULT_LAT(MULT_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .op_mult(op_mult), .op_multu(op_multu),
`ifdef MADD_EN
    .op_madd(op_madd),
`endif
    .op_mthi(op_mthi), .op_mtlo(op_mtlo),
    .rs_val(rs_val), .rt_val(rt_val),
    .mult_a(mult_a), .mult_b(mult_b), .mult_z(mult_z),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Stand-in multiplier: signed product delayed by MULT_LAT edges
  logic [63:0] zp [MULT_LAT];
  initial for (int i = 0; i < MULT_LAT; i++) zp[i] = 64'h0;
  always @(posedge clk) begin
    zp[0] <= 64'(longint'($signed(mult_a)) * longint'($signed(mult_b)));
    for (int i = 1; i < MULT_LAT; i++) zp[i] <= zp[i-1];
  end
  assign mult_z = zp[MULT_LAT-1];

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_ops();
    op_mult = 0; op_multu = 0; op_mthi = 0; op_mtlo = 0;
`ifdef MADD_EN
    op_madd = 0;
`endif
  endtask

  task automatic drive_junk();
    rs_val   = $urandom;
    rt_val   = $urandom;
    op_mthi  = 1'($urandom_range(0, 1));
    op_mtlo  = 1'($urandom_range(0, 1));
    op_mult  = 1'($urandom_range(0, 1));
    op_multu = 1'($urandom_range(0, 1));
  endtask

  // kind: 0 mult, 1 multu, 2 madd, 3 mult+mtlo, 4 mult+multu
  task automatic mul_op(input int kind, input logic [31:0] a, input logic [31:0] b, input bit junk);
    logic [63:0] ps, pu, exp, old;
    int d0;
    ps  = 64'(longint'($signed(a)) * longint'($signed(b)));
    pu  = {32'h0, a} * {32'h0, b};
    exp = (kind == 1) ? pu : (kind == 2) ? m_hl + ps : ps;
    old = m_hl;
    d0  = done_cnt;
    @(negedge clk);
    rs_val = a; rt_val = b;
    case (kind)
      0: op_mult = 1;
      1: op_multu = 1;
`ifdef MADD_EN
      2: op_madd = 1;
`endif
      3: begin op_mult = 1; op_mtlo = 1; end
      default: begin op_mult = 1; op_multu = 1; end
    endcase
    @(negedge clk);
    clear_ops();
    chk("busy_after_issue", {63'h0, busy}, 64'h1);
    chk("mult_ab_issue", {mult_a, mult_b}, {a, b});
    for (int i = 0; i < MULT_LAT; i++) begin
      if (junk) drive_junk();
      @(negedge clk);
      clear_ops();
    end
    chk("done_in_commit", {63'h0, done}, 64'h1);
    chk("hilo_held_before_commit", {hi, lo}, old);
    chk("mult_ab_held", {mult_a, mult_b}, {a, b});
    if (junk) drive_junk();
    @(negedge clk);
    clear_ops();
    m_hl = exp;
    chk("hilo_commit", {hi, lo}, m_hl);
    chk("busy_after_commit", {63'h0, busy}, 64'h0);
    chk("done_pulses", 64'(done_cnt - d0), 64'h1);
  endtask

  task automatic mt_op(input bit to_hi, input logic [31:0] v);
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    rs_val = v;
    if (to_hi) op_mthi = 1; else op_mtlo = 1;
    @(negedge clk);
    clear_ops();
    if (to_hi) m_hl[63:32] = v; else m_hl[31:0] = v;
    chk(to_hi ? "mthi" : "mtlo", {hi, lo}, m_hl);
    chk("mt_no_done", 64'(done_cnt - d0), 64'h0);
    chk("mt_not_busy", {63'h0, busy}, 64'h0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int d0, k;
    repeat (2) @(negedge clk);
    chk("rst_hilo", {hi, lo}, 64'h0);
    chk("rst_ab", {mult_a, mult_b}, 64'h0);
    chk("rst_busy_done", {62'h0, busy, done}, 64'h0);
    reset = 0;
    @(negedge clk);

    // Reset during WAIT discards the in-flight result
    rs_val = 5; rt_val = 7; op_mult = 1;
    @(negedge clk);
    clear_ops();
    chk("midwait_busy", {63'h0, busy}, 64'h1);
    reset = 1;
    #1;
    chk("midwait_rst_hilo", {hi, lo}, 64'h0);
    chk("midwait_rst_busy_done", {62'h0, busy, done}, 64'h0);
    @(negedge clk); @(negedge clk);
    reset = 0;
    d0 = done_cnt;
    repeat (MULT_LAT + 3) @(negedge clk);
    chk("midwait_no_done", 64'(done_cnt - d0), 64'h0);
    chk("midwait_hilo", {hi, lo}, 64'h0);
    chk("midwait_idle", {63'h0, busy}, 64'h0);

    mul_op(0, 32'hFFFF_FFFD, 32'h7, 0);
    chk("signed_m3x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    mul_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("multu_ffff", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    mul_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("mult_ffff", {hi, lo}, 64'h0000_0000_0000_0001);

    // Busy lockout: mthi and a second mult arrive during WAIT
    @(negedge clk);
    rs_val = 2; rt_val = 3; op_mult = 1;
    @(negedge clk);
    clear_ops();
    rs_val = 32'hAAAA_5555; op_mthi = 1;
    @(negedge clk);
    clear_ops();
    rs_val = 9; rt_val = 9; op_mult = 1;
    @(negedge clk);
    clear_ops();
    repeat (MULT_LAT + 2) @(negedge clk);
    chk("lockout_hilo", {hi, lo}, 64'h0000_0000_0000_0006);
    chk("lockout_idle", {63'h0, busy}, 64'h0);
    m_hl = 64'h6;

    mt_op(1, 32'h1234_5678);
    mt_op(0, 32'h9ABC_DEF0);
    chk("mt_pair", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
    mul_op(3, 32'h10, 32'h3, 0);
    chk("mult_beats_mtlo", {hi, lo}, 64'h30);
    mul_op(4, 32'hFFFF_FFFF, 32'h2, 0);
    chk("mult_beats_multu", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);

    for (int n = 0; n < 30; n++) begin
      k = $urandom_range(0, 5);
      case (k)
        0: mul_op(0, pick(), pick(), 1'($urandom_range(0, 1)));
        1: mul_op(1, pick(), pick(), 1'($urandom_range(0, 1)));
        2: mul_op(3, pick(), pick(), 1'($urandom_range(0, 1)));
        3: mul_op(4, pick(), pick(), 1'($urandom_range(0, 1)));
        4: mt_op(1, pick());
        default: mt_op(0, pick());
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef MADD_EN
    mt_op(1, 32'h0);
    mt_op(0, 32'hFFFF_FFFF);
    mul_op(2, 32'h1, 32'h1, 0);
    chk("madd_carry", {hi, lo}, 64'h0000_0001_0000_0000);
    for (int n = 0; n < 6; n++) mul_op(2, pick(), pick(), 1'($urandom_range(0, 1)));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
